// File: rtl/fp_normalize_round.sv
// fp_normalize_round
// Output stage after the single-precision mantissa adder. It takes the raw
// adder result, normalizes it one bit per cycle, rounds to nearest-even and
// packs a binary32 word. Results already resolved upstream (zero/inf/NaN)
// bypass the arithmetic.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset_n        synchronous active-low reset
//   in_valid       upstream result valid
//   in_ready       block can accept (IDLE only)
//   in_sign        result sign
//   in_exp         biased exponent of the larger operand
//   in_mant        [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
//   in_special     bypass arithmetic, emit in_special_val
//   in_special_val bypass word
//   out_valid      result valid
//   out_ready      downstream accepts
//   out_result     packed binary32
//   out_flags      {overflow, underflow, inexact}
//
// state   | meaning
// S_IDLE  | waiting for an operand, in_ready high
// S_NORM  | left-normalizing one bit per cycle
// S_ROUND | round-to-nearest-even and pack
// S_OUT   | result held until out_ready

module fp_normalize_round #(
   parameter int MAX_NORM_SHIFT = 26
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [27:0] in_mant,
   input  logic        in_special,
   input  logic [31:0] in_special_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_flags
);

   localparam int CW = $clog2(MAX_NORM_SHIFT + 1);

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_sign;
   logic                w_sign_nxt;
   logic signed [9:0]   r_exp;
   logic signed [9:0]   w_exp_nxt;
   logic [26:0]         r_mant;
   logic [26:0]         w_mant_nxt;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [31:0]         r_result;
   logic [31:0]         w_result_nxt;
   logic [2:0]          r_flags;
   logic [2:0]          w_flags_nxt;

   logic signed [9:0]   w_exp_in;
   logic [26:0]         w_mant_shl;
   logic                w_g;
   logic                w_rs;
   logic                w_up;
   logic [24:0]         w_sig;
   logic signed [9:0]   w_exp_rnd;
   logic                w_hidden;
   logic [22:0]         w_frac;
   logic                w_ovf;
   logic                w_inexact;
   logic [31:0]         w_round_result;
   logic [2:0]          w_round_flags;

   // A zero exponent field with a nonzero mantissa is a denormal: exponent 1.
   assign w_exp_in   = (in_exp == 8'd0) ? 10'sd1 : $signed({2'b00, in_exp});
   assign w_mant_shl = {r_mant[25:0], 1'b0};

   assign w_g       = r_mant[2];
   assign w_rs      = r_mant[1] | r_mant[0];
   assign w_up      = w_g & (w_rs | r_mant[3]);
   assign w_sig     = {1'b0, r_mant[26:3]} + {24'd0, w_up};
   assign w_exp_rnd = r_exp + $signed({9'd0, w_sig[24]});
   // On a rounding carry the significand is exactly 1.0 x 2, so fraction is 0.
   assign w_hidden  = w_sig[24] | w_sig[23];
   assign w_frac    = w_sig[24] ? 23'd0 : w_sig[22:0];
   assign w_ovf     = (w_exp_rnd >= 10'sd255);
   assign w_inexact = w_g | w_rs;

   always_comb begin
      w_round_result = {r_sign, (w_hidden ? w_exp_rnd[7:0] : 8'd0), w_frac};
      w_round_flags  = {1'b0, ~w_hidden & w_inexact, w_inexact};
      if (w_ovf) begin
         w_round_result = {r_sign, 8'hFF, 23'd0};
         w_round_flags  = 3'b101;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sign_nxt   = r_sign;
      w_exp_nxt    = r_exp;
      w_mant_nxt   = r_mant;
      w_cnt_nxt    = r_cnt;
      w_result_nxt = r_result;
      w_flags_nxt  = r_flags;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_sign_nxt = in_sign;
               w_exp_nxt  = w_exp_in;
               w_cnt_nxt  = '0;
               w_mant_nxt = in_mant[26:0];
               if (in_special) begin
                  w_result_nxt = in_special_val;
                  w_flags_nxt  = 3'b000;
                  w_state_nxt  = S_OUT;
               end else if (in_mant == 28'd0) begin
                  w_result_nxt = 32'h0000_0000;
                  w_flags_nxt  = 3'b000;
                  w_state_nxt  = S_OUT;
               end else if (in_mant[27]) begin
                  // Carry-out: shift right once, folding the lost bit into sticky.
                  w_mant_nxt  = {in_mant[27:2], in_mant[1] | in_mant[0]};
                  w_exp_nxt   = w_exp_in + 10'sd1;
                  w_state_nxt = S_ROUND;
               end else if (in_mant[26]) begin
                  w_state_nxt = S_ROUND;
               end else begin
                  w_state_nxt = S_NORM;
               end
            end
         end
         S_NORM: begin
            if (r_mant[26] || (r_exp == 10'sd1) || (r_cnt == CW'(MAX_NORM_SHIFT))) begin
               w_state_nxt = S_ROUND;
            end else begin
               w_mant_nxt = w_mant_shl;
               w_exp_nxt  = r_exp - 10'sd1;
               w_cnt_nxt  = r_cnt + 1'b1;
               // Look ahead at the shifted value so the last shift and the
               // move to ROUND share one edge.
               if (w_mant_shl[26] || (r_exp == 10'sd2) ||
                   (r_cnt == CW'(MAX_NORM_SHIFT - 1))) begin
                  w_state_nxt = S_ROUND;
               end
            end
         end
         S_ROUND: begin
            w_result_nxt = w_round_result;
            w_flags_nxt  = w_round_flags;
            w_state_nxt  = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_mant   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sign   <= w_sign_nxt;
         r_exp    <= w_exp_nxt;
         r_mant   <= w_mant_nxt;
         r_cnt    <= w_cnt_nxt;
         r_result <= w_result_nxt;
         r_flags  <= w_flags_nxt;
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_OUT);
   assign out_result = r_result;
   assign out_flags  = r_flags;

endmodule

// File: tb/tb_fp_normalize_round.sv
module tb_fp_normalize_round;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [27:0] in_mant;
   logic        in_special;
   logic [31:0] in_special_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;   // -1: latency not checked
   } exp_t;

   exp_t sb_q[$];

   fp_normalize_round #(.MAX_NORM_SHIFT(26)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_exp         (in_exp),
      .in_mant        (in_mant),
      .in_special     (in_special),
      .in_special_val (in_special_val),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_flags      (out_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t ref_model(input logic s, input logic [7:0] e8,
                                      input logic [27:0] m28, input logic sp,
                                      input logic [31:0] sv);
      exp_t        r;
      int          e;
      int          er;
      int          k;
      logic [26:0] m;
      logic [24:0] s25;
      logic        g;
      logic        rs;
      e = (e8 == 8'd0) ? 1 : int'(e8);
      if (sp) begin
         r.res = sv; r.flg = 3'b000; r.lat = 1;
         return r;
      end
      if (m28 == 28'd0) begin
         r.res = 32'h0; r.flg = 3'b000; r.lat = 1;
         return r;
      end
      if (m28[27]) begin
         m = {m28[27:2], m28[1] | m28[0]};
         e++;
         r.lat = 2;
      end else if (m28[26]) begin
         m = m28[26:0];
         r.lat = 2;
      end else begin
         m = m28[26:0];
         k = 0;
         while (!m[26] && e > 1 && k < 26) begin
            m = {m[25:0], 1'b0};
            e--;
            k++;
         end
         r.lat = (k == 0) ? -1 : 2 + k;
      end
      g   = m[2];
      rs  = m[1] | m[0];
      s25 = {1'b0, m[26:3]};
      if (g && (rs || m[3])) s25 = s25 + 25'd1;
      er = e;
      if (s25[24]) begin
         er++;
         s25 = s25 >> 1;
      end
      if (er >= 255) begin
         r.res = {s, 8'hFF, 23'd0};
         r.flg = 3'b101;
      end else if (!s25[23]) begin
         r.res = {s, 8'h00, s25[22:0]};
         r.flg = {1'b0, g | rs, g | rs};
      end else begin
         r.res = {s, 8'(er), s25[22:0]};
         r.flg = {2'b00, g | rs};
      end
      return r;
   endfunction

   // Drives one operation, waits for its result and completes the handshake.
   task automatic run_op(input string tag, input logic s, input logic [7:0] e8,
                         input logic [27:0] m28, input logic sp, input logic [31:0] sv,
                         input logic use_const, input logic [31:0] cres,
                         input logic [2:0] cflg, input int clat);
      exp_t x;
      exp_t y;
      int   lat;
      if (use_const) begin
         x.res = cres; x.flg = cflg; x.lat = clat;
      end else begin
         x = ref_model(s, e8, m28, sp, sv);
      end
      sb_q.push_back(x);
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_sign = s; in_exp = e8; in_mant = m28; in_special = sp; in_special_val = sv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      y = sb_q.pop_front();
      if (y.lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(y.lat));
      chk({tag, "_result"}, out_result, y.res);
      chk({tag, "_flags"}, 32'(out_flags), 32'(y.flg));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_drain"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      exp_t        x;
      exp_t        y;
      int          lat;
      logic        s_ok;
      logic [27:0] rm;
      logic [7:0]  re;

      reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'd0; in_mant = 28'd0;
      in_special = 1'b0; in_special_val = 32'd0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", out_result, 32'd0);
      chk("rst_flags", 32'(out_flags), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_op("norm_exact", 1'b0, 8'h7F, 28'h6000000, 1'b0, 32'd0, 1'b1, 32'h3FC00000, 3'b000, 2);
      run_op("carry",      1'b0, 8'h7F, 28'h8000000, 1'b0, 32'd0, 1'b1, 32'h40000000, 3'b000, 2);
      run_op("carry_ovf",  1'b0, 8'hFE, 28'h8000000, 1'b0, 32'd0, 1'b1, 32'h7F800000, 3'b101, 2);
      run_op("cancel",     1'b0, 8'h7F, 28'h0000008, 1'b0, 32'd0, 1'b1, 32'h34000000, 3'b000, 25);
      run_op("rne_up",     1'b0, 8'h7F, 28'h400000C, 1'b0, 32'd0, 1'b1, 32'h3F800002, 3'b001, 2);
      run_op("rne_tie",    1'b0, 8'h7F, 28'h4000014, 1'b0, 32'd0, 1'b1, 32'h3F800002, 3'b001, 2);
      run_op("rne_carry",  1'b0, 8'h7F, 28'h7FFFFFD, 1'b0, 32'd0, 1'b1, 32'h40000000, 3'b001, 2);
      run_op("denorm",     1'b0, 8'h01, 28'h0000010, 1'b0, 32'd0, 1'b1, 32'h00000002, 3'b000, -1);
      run_op("denorm_inx", 1'b0, 8'h01, 28'h0000014, 1'b0, 32'd0, 1'b1, 32'h00000002, 3'b011, -1);
      run_op("denorm_up",  1'b0, 8'h01, 28'h3FFFFFD, 1'b0, 32'd0, 1'b1, 32'h00800000, 3'b001, -1);
      run_op("exp0",       1'b0, 8'h00, 28'h4000000, 1'b0, 32'd0, 1'b1, 32'h00800000, 3'b000, 2);
      run_op("zero_neg",   1'b1, 8'h40, 28'h0000000, 1'b0, 32'd0, 1'b1, 32'h00000000, 3'b000, 1);
      run_op("neg_norm",   1'b1, 8'h80, 28'h4000000, 1'b0, 32'd0, 1'b1, 32'hC0000000, 3'b000, 2);
      run_op("spec_inf",   1'b1, 8'h00, 28'h0000000, 1'b1, 32'hFF800000, 1'b1, 32'hFF800000, 3'b000, 1);

      for (int i = 0; i < 24; i++) begin
         rm = 28'($urandom) >> $urandom_range(0, 27);
         re = 8'($urandom_range(0, 255));
         run_op("rand", 1'($urandom), re, rm, ($urandom_range(0, 9) == 0),
                $urandom, 1'b0, 32'd0, 3'b000, 0);
      end

      // Special result held against a stalled sink while upstream offers another op.
      x.res = 32'h7FC00001; x.flg = 3'b000; x.lat = 1;
      sb_q.push_back(x);
      @(negedge clk);
      in_special = 1'b1; in_special_val = 32'h7FC00001; in_sign = 1'b0;
      in_exp = 8'h00; in_mant = 28'd0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_out_valid", 32'(out_valid), 32'd1);
      in_special = 1'b0; in_exp = 8'h7F; in_mant = 28'h6000000;
      s_ok = 1'b1;
      y = sb_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("hs_hold_result", out_result, y.res);
         chk("hs_hold_in_ready", 32'(in_ready), 32'd0);
         chk("hs_hold_valid", 32'(out_valid), 32'd1);
      end
      chk("hs_flags", 32'(out_flags), 32'(y.flg));
      x.res = 32'h3FC00000; x.flg = 3'b000; x.lat = 2;
      sb_q.push_back(x);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hs_release_valid", 32'(out_valid), 32'd0);
      chk("hs_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hs_second_accept", 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      y = sb_q.pop_front();
      chk("hs_second_latency", 32'(lat), 32'(y.lat));
      chk("hs_second_result", out_result, y.res);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset in the middle of a long normalization discards the operation.
      @(negedge clk);
      in_special = 1'b0; in_exp = 8'h7F; in_mant = 28'h0000008; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      s_ok = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) s_ok = 1'b0;
      end
      chk("midrst_no_output", 32'(s_ok), 32'd1);
      chk("midrst_idle", 32'(in_ready), 32'd1);

      run_op("post_rst", 1'b0, 8'h7F, 28'h0000008, 1'b0, 32'd0, 1'b1, 32'h34000000, 3'b000, 25);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
